// File: rtl/cmul_pkg.sv
// Shared types and widths for the round-robin complex-multiply scheduler.
package cmul_pkg;

    localparam int OPW   = 8;
    localparam int RESW  = 17;
    localparam int SLOTW = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    // Two's-complement negation clamped so -128 maps to +127.
    function automatic logic signed [OPW-1:0] neg_sat(input logic signed [OPW-1:0] v);
        logic signed [OPW-1:0] res;
        res = (v == 8'sh80) ? 8'sh7F : -v;
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic found_s;
    logic hit_s;

    // Scan offsets 1..N from ptr; the first requesting slot wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int j = 1; j <= N; j++) begin
            for (int i = 0; i < N; i++) begin
                hit_s   = !found_s && req[i] && (i == ((int'(ptr) + j) % N));
                gnt[i]  = gnt[i] | hit_s;
                idx     = hit_s ? IDW'(i) : idx;
                found_s = found_s | hit_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cmul_rr_sched.sv
// Round-robin scheduler sharing one two-cycle complex multiplier between N requesters.
// Define CMUL_RR_SCHED_CONJ_EN to add req_conj (conjugate b before multiplying).
module cmul_rr_sched
    import cmul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
`ifdef CMUL_RR_SCHED_CONJ_EN
    input  logic [N-1:0]           req_conj,
`endif
    input  logic [N*SLOTW-1:0]     req_data,
    output logic [N-1:0]           gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic signed [RESW-1:0] rsp_r,
    output logic signed [RESW-1:0] rsp_i,
    output logic                   m_en,
    output logic signed [OPW-1:0]  m_a_r,
    output logic signed [OPW-1:0]  m_a_i,
    output logic signed [OPW-1:0]  m_b_r,
    output logic signed [OPW-1:0]  m_b_i,
    input  logic signed [RESW-1:0] m_o_r,
    input  logic signed [RESW-1:0] m_o_i
);

    state_t                 state_r, state_s;
    logic [IDW-1:0]         ptr_r;
    logic [N-1:0]           pick_gnt_s;
    logic [IDW-1:0]         pick_idx_s;
    logic                   pick_any_s;
    logic [N-1:0]           gnt_s;
    logic                   fire_s;
    logic [SLOTW-1:0]       slot_s;
    logic signed [OPW-1:0]  bi_s;

    logic                   m_en_r;
    logic signed [OPW-1:0]  op_ar_r, op_ai_r, op_br_r, op_bi_r;
    logic                   rsp_valid_r;
    logic [IDW-1:0]         rsp_id_r;
    logic signed [RESW-1:0] rsp_r_r, rsp_i_r;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // One-hot mux of the winning requester's operand slot.
    always_comb begin
        slot_s = '0;
        for (int k = 0; k < N; k++) begin
            slot_s = slot_s | (req_data[k*SLOTW +: SLOTW] & {SLOTW{pick_gnt_s[k]}});
        end
    end

`ifdef CMUL_RR_SCHED_CONJ_EN
    // Optional conjugation of b, saturating the one unrepresentable case.
    always_comb begin
        if (|(req_conj & pick_gnt_s)) begin
            bi_s = neg_sat(slot_s[OPW-1:0]);
        end else begin
            bi_s = slot_s[OPW-1:0];
        end
    end
`else
    assign bi_s = slot_s[OPW-1:0];
`endif

    // Next-state logic; a grant only happens from IDLE.
    always_comb begin
        state_s = state_r;
        gnt_s   = '0;
        fire_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    gnt_s   = pick_gnt_s;
                    fire_s  = 1'b1;
                    state_s = MUL0;
                end else begin
                    state_s = IDLE;
                end
            end
            MUL0: state_s = MUL1;
            MUL1: state_s = CAPT;
            CAPT: state_s = RESP;
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Grant is combinational, so it is masked while reset is held.
    always_comb begin
        if (rst) begin
            gnt = '0;
        end else begin
            gnt = gnt_s;
        end
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= IDW'(N-1);
            m_en_r      <= 1'b0;
            op_ar_r     <= '0;
            op_ai_r     <= '0;
            op_br_r     <= '0;
            op_bi_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_r_r     <= '0;
            rsp_i_r     <= '0;
        end else begin
            state_r <= state_s;
            m_en_r  <= fire_s;
            if (fire_s) begin
                ptr_r   <= pick_idx_s;
                op_ar_r <= slot_s[4*OPW-1:3*OPW];
                op_ai_r <= slot_s[3*OPW-1:2*OPW];
                op_br_r <= slot_s[2*OPW-1:OPW];
                op_bi_r <= bi_s;
            end
            // ptr_r still holds the owner's index when the result lands.
            if (state_r == CAPT) begin
                rsp_valid_r <= 1'b1;
                rsp_id_r    <= ptr_r;
                rsp_r_r     <= m_o_r;
                rsp_i_r     <= m_o_i;
            end else if (rsp_valid_r && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign m_en      = m_en_r;
    assign m_a_r     = op_ar_r;
    assign m_a_i     = op_ai_r;
    assign m_b_r     = op_br_r;
    assign m_b_i     = op_bi_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_r     = rsp_r_r;
    assign rsp_i     = rsp_i_r;

endmodule

// File: tb/tb_cmul_rr_sched.sv
// Scoreboard bench for cmul_rr_sched with a two-cycle complex multiplier model.
module tb_cmul_rr_sched;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N*32-1:0]      req_data;
    logic [N-1:0]         gnt;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic signed [16:0]   rsp_r, rsp_i;
    logic                 m_en;
    logic signed [7:0]    m_a_r, m_a_i, m_b_r, m_b_i;
    logic signed [16:0]   m_o_r, m_o_i;
`ifdef CMUL_RR_SCHED_CONJ_EN
    logic [N-1:0]         req_conj;
`endif

    cmul_rr_sched #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef CMUL_RR_SCHED_CONJ_EN
        .req_conj  (req_conj),
`endif
        .req_data  (req_data),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_i     (rsp_i),
        .m_en      (m_en),
        .m_a_r     (m_a_r),
        .m_a_i     (m_a_i),
        .m_b_r     (m_b_r),
        .m_b_i     (m_b_i),
        .m_o_r     (m_o_r),
        .m_o_i     (m_o_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared multiplier: products one cycle after m_en, sums the cycle after.
    logic               mv1;
    logic signed [15:0] p_rr, p_ii, p_ri, p_ir;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv1 <= 1'b0; p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
            m_o_r <= '0; m_o_i <= '0;
        end else begin
            mv1 <= m_en;
            if (m_en) begin
                p_rr <= m_a_r * m_b_r;
                p_ii <= m_a_i * m_b_i;
                p_ri <= m_a_r * m_b_i;
                p_ir <= m_a_i * m_b_r;
            end
            if (mv1) begin
                m_o_r <= p_rr - p_ii;
                m_o_i <= p_ri + p_ir;
            end
        end
    end

    typedef struct { int id; int r; int i; } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int r, input int i);
        exp_t e;
        e.id = id; e.r = r; e.i = i;
        exp_q.push_back(e);
    endtask

    // Response monitor: pops on each handshake, checks stability while stalled.
    initial begin
        logic stall;
        int   st_id, st_r, st_i;
        exp_t e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", rsp_valid, 1);
                    chk("stall_id", rsp_id, st_id);
                    chk("stall_r", rsp_r, st_r);
                    chk("stall_i", rsp_i, st_i);
                end
                if (rsp_valid && rsp_ready) begin
                    stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id %0d with none expected", rsp_id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_r", rsp_r, e.r);
                        chk("rsp_i", rsp_i, e.i);
                    end
                end else if (rsp_valid) begin
                    stall = 1'b1;
                    st_id = rsp_id; st_r = rsp_r; st_i = rsp_i;
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_slot(input int k, input int ar, input int ai, input int br, input int bi);
        req_data[32*k +: 32] = {8'(ar), 8'(ai), 8'(br), 8'(bi)};
    endtask

    task automatic wait_gnt(input string name, input int idx);
        int n;
        n = 0;
        #1;
        while (gnt == '0 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk(name, gnt, 32'(1) << idx);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk(name, exp_q.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int order [5] = '{0, 1, 2, 3, 0};
    int ex_r  [4] = '{-5, 13, 200, 0};
    int ex_i  [4] = '{10, 82, 0, 2};
    int last_g;

    initial begin
        rst = 1'b1; req = '0; req_data = '0; rsp_ready = 1'b1;
`ifdef CMUL_RR_SCHED_CONJ_EN
        req_conj = '0;
`endif
        step(); step();
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_men", m_en, 0);
        chk("rst_rsp_r", rsp_r, 0);
        rst = 1'b0;
        step();

        // Single request with latency/pulse-width checks.
        set_slot(0, 3, 4, 5, -2);
        req = 4'b0001;
        wait_gnt("t1_gnt", 0);
        push(0, 23, 14);
        step();
        req = 4'b0000;
        chk("t1_gnt_busy", gnt, 0);
        chk("t1_men_on", m_en, 1);
        chk("t1_m_a_r", m_a_r, 3);
        chk("t1_m_a_i", m_a_i, 4);
        chk("t1_m_b_r", m_b_r, 5);
        chk("t1_m_b_i", m_b_i, -2);
        step();
        chk("t1_men_off", m_en, 0);
        chk("t1_hold_a_r", m_a_r, 3);
        step();
        chk("t1_valid_early", rsp_valid, 0);
        step();
        chk("t1_valid_t4", rsp_valid, 1);
        drain("t1_drain");

        // Reset restores ptr so requester 0 leads; all four request continuously.
        rst = 1'b1; step(); rst = 1'b0;
        set_slot(0, 1, 2, 3, 4);
        set_slot(1, -5, 6, 7, -8);
        set_slot(2, 10, -10, 10, 10);
        set_slot(3, -1, -1, -1, -1);
        req = 4'b1111;
        last_g = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt("t2_order", order[g]);
            if (g > 0) chk("t2_spacing", cyc - last_g, 5);
            last_g = cyc;
            push(order[g], ex_r[order[g]], ex_i[order[g]]);
            step();
        end
        req = 4'b0000;
        drain("t2_drain");

        // Backpressure: three stalled RESP cycles, loser waits for the handshake.
        rsp_ready = 1'b0;
        set_slot(2, 7, 7, 7, 7);
        req = 4'b0100;
        wait_gnt("t3_gnt", 2);
        push(2, 0, 98);
        step();
        req = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) step();
            chk("t3_no_gnt", gnt, 0);
            if (k >= 4) chk("t3_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("t3_gnt_after_hs", gnt, 4'b0010);
        push(1, 13, 82);
        step();
        req = 4'b0000;
        drain("t3_drain");

        // Reset during MUL1 aborts with no response.
        req = 4'b1000;
        wait_gnt("t4_gnt", 3);
        step();
        req = 4'b0000;
        step();
        rst = 1'b1;
        req = 4'b1111;
        #1;
        chk("t4_gnt", gnt, 0);
        chk("t4_men", m_en, 0);
        chk("t4_valid", rsp_valid, 0);
        chk("t4_rsp_r", rsp_r, 0);
        chk("t4_rsp_i", rsp_i, 0);
        chk("t4_rsp_id", rsp_id, 0);
        chk("t4_m_a_r", m_a_r, 0);
        chk("t4_m_b_i", m_b_i, 0);
        step(); step();
        rst = 1'b0;
        wait_gnt("t4_first_after_rst", 0);
        push(0, -5, 10);
        step();
        req = 4'b0000;
        drain("t4_drain");

        // Full-range operands.
        set_slot(1, -128, -128, -128, -128);
        req = 4'b0010;
        wait_gnt("t5_gnt_a", 1);
        push(1, 0, 32768);
        step();
        req = 4'b0000;
        drain("t5_drain_a");
        set_slot(2, 127, -128, -128, 127);
        req = 4'b0100;
        wait_gnt("t5_gnt_b", 2);
        push(2, 0, 32513);
        step();
        req = 4'b0000;
        drain("t5_drain_b");

`ifdef CMUL_RR_SCHED_CONJ_EN
        // Conjugated b, including the saturating -128 case.
        set_slot(1, 3, 4, 5, 2);
        req_conj = 4'b0010;
        req = 4'b0010;
        wait_gnt("t6_gnt_a", 1);
        push(1, 23, 14);
        step();
        req = 4'b0000;
        chk("t6_m_b_i_neg", m_b_i, -2);
        drain("t6_drain_a");
        set_slot(2, 1, 0, 0, -128);
        req_conj = 4'b0100;
        req = 4'b0100;
        wait_gnt("t6_gnt_b", 2);
        push(2, 0, 127);
        step();
        req = 4'b0000;
        chk("t6_m_b_i_sat", m_b_i, 127);
        drain("t6_drain_b");
        req_conj = 4'b0000;
`endif

        chk("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmul_rr_sched.md
Name: cmul_rr_sched

Overview:
- Round-robin scheduler that shares one two-cycle complex multiplier (8-bit signed operands, 17-bit signed results) between N requesters.
- Per operation it:
  - picks a winner and latches its operands;
  - pulses the multiplier start;
  - holds the operands for the multiplier's two compute cycles;
  - captures real/imag results and returns them with the requester id under a valid/ready handshake.
- Sits between the per-channel complex-multiply clients and the shared multiplier instance.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= N.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request per requester; held until granted.
- req_data  in  N*32  per-requester operands, slot k = bits [32k+31:32k] = {a_r,a_i,b_r,b_i}, each signed 8-bit.
- gnt  out  N  one-hot one-cycle accept pulse; operands of slot k are latched in that cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of requester that owns the result.
- rsp_r  out  17  signed real result, a_r*b_r - a_i*b_i.
- rsp_i  out  17  signed imag result, a_r*b_i + a_i*b_r.
- m_en  out  1  multiplier start pulse.
- m_a_r, m_a_i, m_b_r, m_b_i  out  8 each  signed multiplier operands.
- m_o_r, m_o_i  in  17 each  multiplier results.

Behaviour:
- Reset: clk, rst as decided (rst asynchronous, active-high).
  - State goes to IDLE; RR pointer resets to N-1, so requester 0 has first priority.
  - All outputs 0; operand and result registers 0.
  - Reset mid-operation aborts the operation with no response; the multiplier shares rst.
- States: IDLE -> MUL0 -> MUL1 -> CAPT -> RESP -> IDLE.
- IDLE:
  - If req != 0, choose the first set bit searching from ptr+1 upward with wrap.
  - Assert gnt[w] combinationally in this cycle.
  - At the edge: latch slot w operands and id w, set ptr <= w, go to MUL0.
  - If req == 0, stay in IDLE and gnt = 0.
- MUL0: m_en=1; operands driven from registers.
- MUL1: m_en=0; operands held.
- CAPT: operands held; at the edge rsp_r <= m_o_r and rsp_i <= m_o_i.
- RESP:
  - rsp_valid=1; rsp_id, rsp_r, rsp_i stable until handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
- m_a_*/m_b_* stay at the last latched operands outside an operation.
- Latency: grant in cycle t, rsp_valid from cycle t+4. Minimum spacing between grants is 5 cycles.
- No new grant while busy; req of losers is ignored until IDLE.
- A requester deasserting req before grant is legal (no effect).
- Arithmetic: no truncation. Full range fits, e.g. (-128,-128)*(-128,-128) imag = 32768.
- Stall: rsp_ready low holds RESP indefinitely, with outputs unchanged.

Optional Feature:
- Macro CMUL_RR_SCHED_CONJ_EN.
- Defined:
  - Adds input req_conj [N-1:0], sampled with the grant.
  - When set, b_i is negated before latching, i.e. conj(b).
  - -128 negates to +127 (saturated).
- Undefined: port absent; b_i latched unchanged.

Decomposition:
- Package cmul_pkg:
  - state encoding (IDLE, MUL0, MUL1, CAPT, RESP);
  - operand width 8, result width 17, slot width 32.
- Sub-module rr_pick:
  - combinational round-robin select;
  - inputs req, ptr; outputs one-hot gnt, index, any.

Test Plan:
- Single request: req0 with a=(3,4), b=(5,-2), rsp_ready=1.
  - gnt[0] pulses 1 cycle; m_en pulses 1 cycle later.
  - rsp_valid 4 cycles after gnt with id=0, rsp_r=23, rsp_i=14.
- All four requesting continuously.
  - Grant order 0,1,2,3,0; gnt pulses exactly 5 cycles apart.
  - rsp_id matches the grant order.
- Backpressure: rsp_ready low for 3 cycles in RESP.
  - rsp_valid/id/data stable; no new gnt until the cycle after handshake.
- Extremes: a=(-128,-128), b=(-128,-128) -> rsp_r=0, rsp_i=32768.
  - a=(127,-128), b=(-128,127) -> rsp_r=0, rsp_i=32513.
- rst asserted in MUL1.
  - All outputs 0 immediately; no response.
  - Next grant goes to requester 0 first.
- With CMUL_RR_SCHED_CONJ_EN:
  - req_conj[1]=1, a=(3,4), b=(5,2) -> (23,14).
  - b_i=-128 with conj: m_b_i=127.
